// File: rtl/strength_resolve_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strength_resolve_pipe_pkg                                            |
// | Value/strength encodings and tie helper for net strength resolution. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package strength_resolve_pipe_pkg;

  typedef logic [2:0] str_t;
  typedef logic [1:0] val_t;

  localparam val_t V0 = 2'b00;
  localparam val_t V1 = 2'b01;
  localparam val_t VZ = 2'b10;
  localparam val_t VX = 2'b11;

  localparam str_t ST_SUPPLY = 3'd7;
  localparam str_t ST_STRONG = 3'd6;
  localparam str_t ST_PULL   = 3'd5;
  localparam str_t ST_LARGE  = 3'd4;
  localparam str_t ST_WEAK   = 3'd3;
  localparam str_t ST_MEDIUM = 3'd2;
  localparam str_t ST_SMALL  = 3'd1;
  localparam str_t ST_HIGHZ  = 3'd0;

  typedef enum logic [1:0] {
    NK_WIRE = 2'd0,
    NK_WAND = 2'd1,
    NK_WOR  = 2'd2
  } net_kind_e;

  // An X driver sitting at the winning strength poisons the net whatever the net kind.
  function automatic val_t tie_value(input net_kind_e kind, input logic x_at_max);
    val_t v;
    v = VX;
    if (!x_at_max) begin
      case (kind)
        NK_WAND: v = V0;
        NK_WOR:  v = V1;
        default: v = VX;
      endcase
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strength_resolve_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strength_resolve_pipe_if                                             |
// | Driver-set input and resolved-net output handshake bundle.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface strength_resolve_pipe_if #(
  parameter int NDRV = 3,
  parameter int W    = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NDRV*W*2-1:0]   in_val;
  logic [NDRV*3-1:0]     in_str;
  logic                  out_valid;
  logic                  out_ready;
  logic [W*2-1:0]        out_val;
  logic [W*3-1:0]        out_str;

  modport master (
    output in_valid, in_val, in_str, out_ready,
    input  in_ready, out_valid, out_val, out_str
  );

  modport slave (
    input  in_valid, in_val, in_str, out_ready,
    output in_ready, out_valid, out_val, out_str
  );
endinterface
`default_nettype wire

// File: rtl/strength_resolve_pipe_bit_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strength_resolve_pipe_bit_resolve                                    |
// | Combinational per-bit reduction of NDRV drivers to S0/S1/tie/X flags.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module strength_resolve_pipe_bit_resolve
  import strength_resolve_pipe_pkg::*;
#(
  parameter int NDRV = 3
) (
  input  logic [NDRV*2-1:0] i_val,
  input  logic [NDRV*3-1:0] i_str,
  output str_t              o_s0,
  output str_t              o_s1,
  output logic              o_tie,
  output logic              o_x_at_max
);

  str_t w_s0;
  str_t w_s1;
  str_t w_sx;

  always_comb begin : p_reduce
    val_t v;
    str_t s;
    v    = VZ;
    s    = ST_HIGHZ;
    w_s0 = ST_HIGHZ;
    w_s1 = ST_HIGHZ;
    w_sx = ST_HIGHZ;
    for (int d = 0; d < NDRV; d++) begin
      v = i_val[d*2 +: 2];
      s = i_str[d*3 +: 3];
      if (v != VZ && s != ST_HIGHZ) begin
        // X contributes to both sides, so it always lands on a tie when it wins.
        if ((v == V1 || v == VX) && s > w_s1) w_s1 = s;
        if ((v == V0 || v == VX) && s > w_s0) w_s0 = s;
        if (v == VX && s > w_sx)              w_sx = s;
      end
    end
  end

  assign o_s0       = w_s0;
  assign o_s1       = w_s1;
  assign o_tie      = (w_s0 == w_s1) && (w_s1 != ST_HIGHZ);
  assign o_x_at_max = (w_sx != ST_HIGHZ) && (w_sx == w_s1);

endmodule
`default_nettype wire

// File: rtl/strength_resolve_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | strength_resolve_pipe                                                |
// | Two-stage valid/ready pipeline resolving NDRV strength drivers.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module strength_resolve_pipe
  import strength_resolve_pipe_pkg::*;
#(
  parameter int NDRV     = 3,
  parameter int W        = 1,
  parameter int NET_KIND = 0,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  strength_resolve_pipe_if.slave bus,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam net_kind_e c_net_kind = net_kind_e'(NET_KIND);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;

  str_t [W-1:0]     w_s0;
  str_t [W-1:0]     w_s1;
  logic [W-1:0]     w_tie;
  logic [W-1:0]     w_xmax;

  logic             r_st1_valid;
  str_t [W-1:0]     r_st1_s0;
  str_t [W-1:0]     r_st1_s1;
  logic [W-1:0]     r_st1_tie;
  logic [W-1:0]     r_st1_xmax;

  logic             r_out_valid;
  logic [W*2-1:0]   r_out_val;
  logic [W*3-1:0]   r_out_str;
  logic [W*2-1:0]   w_res_val;
  logic [W*3-1:0]   w_res_str;

  logic [CNT_W-1:0] r_cnt;
  logic             w_s2_take;
  logic             w_in_ready;
  logic             w_cnt_inc;

  // Reset asserts immediately through the flop clear but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [NDRV*2-1:0] w_bit_val;
    for (genvar d = 0; d < NDRV; d++) begin : g_drv
      assign w_bit_val[d*2 +: 2] = bus.in_val[(d*W+b)*2 +: 2];
    end
    strength_resolve_pipe_bit_resolve #(.NDRV(NDRV)) u_res (
      .i_val      (w_bit_val),
      .i_str      (bus.in_str),
      .o_s0       (w_s0[b]),
      .o_s1       (w_s1[b]),
      .o_tie      (w_tie[b]),
      .o_x_at_max (w_xmax[b])
    );
  end

  assign w_s2_take  = !r_out_valid || bus.out_ready;
  assign w_in_ready = w_rst_n && (!r_st1_valid || w_s2_take);
  assign w_cnt_inc  = w_s2_take && r_st1_valid && (|r_st1_tie);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_st1_valid <= 1'b0;
      r_st1_s0    <= '0;
      r_st1_s1    <= '0;
      r_st1_tie   <= '0;
      r_st1_xmax  <= '0;
    end else if (w_in_ready) begin
      r_st1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_st1_s0   <= w_s0;
        r_st1_s1   <= w_s1;
        r_st1_tie  <= w_tie;
        r_st1_xmax <= w_xmax;
      end
    end
  end

  always_comb begin
    w_res_val = {W{VZ}};
    w_res_str = '0;
    for (int b = 0; b < W; b++) begin
      if (r_st1_s1[b] == ST_HIGHZ && r_st1_s0[b] == ST_HIGHZ) begin
        w_res_val[b*2 +: 2] = VZ;
        w_res_str[b*3 +: 3] = ST_HIGHZ;
      end else if (r_st1_s1[b] > r_st1_s0[b]) begin
        w_res_val[b*2 +: 2] = V1;
        w_res_str[b*3 +: 3] = r_st1_s1[b];
      end else if (r_st1_s0[b] > r_st1_s1[b]) begin
        w_res_val[b*2 +: 2] = V0;
        w_res_str[b*3 +: 3] = r_st1_s0[b];
      end else begin
        w_res_val[b*2 +: 2] = tie_value(c_net_kind, r_st1_xmax[b]);
        w_res_str[b*3 +: 3] = r_st1_s0[b];
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_val   <= {W{VZ}};
      r_out_str   <= '0;
    end else if (w_s2_take) begin
      r_out_valid <= r_st1_valid;
      if (r_st1_valid) begin
        r_out_val <= w_res_val;
        r_out_str <= w_res_str;
      end
    end
  end

  // Clear has priority; the count sticks at all-ones.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                          r_cnt <= '0;
    else if (clr_cnt)                      r_cnt <= '0;
    else if (w_cnt_inc && r_cnt != '1)     r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_val   = r_out_val;
  assign bus.out_str   = r_out_str;
  assign conflict_cnt  = r_cnt;

endmodule
`default_nettype wire
